// File: rtl/ctrl_sequencer_if.sv
// Opcode intake, decoder and control-word issue bundle for ctrl_sequencer.
interface ctrl_sequencer_if #(
    parameter int unsigned OPC_W = 7,
    parameter int unsigned CW_W  = 26
);
    logic             op_valid;
    logic             op_ready;
    logic [OPC_W-1:0] op_code;
    logic [1:0]       op_rep;
    logic [OPC_W-1:0] dec_op;
    logic [CW_W-1:0]  dec_cw;
    logic             cw_valid;
    logic             cw_ready;
    logic [CW_W-1:0]  cw_data;
    logic             cw_last;

    // Sequencer side
    modport master (
        input  op_valid, op_code, op_rep, dec_cw, cw_ready,
        output op_ready, dec_op, cw_valid, cw_data, cw_last
    );

    // Front end / decoder / datapath side
    modport slave (
        output op_valid, op_code, op_rep, dec_cw, cw_ready,
        input  op_ready, dec_op, cw_valid, cw_data, cw_last
    );
endinterface

// File: rtl/ctrl_sequencer.sv
// Multi-cycle issue controller: accepts an opcode, lets the decoder settle for
// one cycle, then issues the captured control word 1-4 times downstream.
module ctrl_sequencer #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    ctrl_sequencer_if.master bus,
    input  logic             flush,
    output logic             busy,
    output logic             err,
    input  logic             err_clr,
    output logic [CNT_W-1:0] issued_cnt
);
    localparam int unsigned MARK_BIT = 23;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        ISSUE  = 2'd2
    } state_t;

    state_t     state;
    logic [1:0] rep_cnt;
    logic       accept;
    logic       beat;
    logic       err_set;

    // Ready while idle or when the final beat is taken; never during flush/reset
    assign bus.op_ready = rst_n & ~flush &
                          ((state == IDLE) |
                           ((state == ISSUE) & bus.cw_last & bus.cw_ready));
    assign accept  = bus.op_valid & bus.op_ready;
    assign beat    = (state == ISSUE) & bus.cw_valid & bus.cw_ready & ~flush;
    assign err_set = (state == DECODE) & ~flush & ~bus.dec_cw[MARK_BIT];

    // Sequencer FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            rep_cnt      <= 2'd0;
            bus.dec_op   <= '0;
            bus.cw_data  <= '0;
            bus.cw_valid <= 1'b0;
            bus.cw_last  <= 1'b0;
            busy         <= 1'b0;
            issued_cnt   <= '0;
        end else if (flush) begin
            state        <= IDLE;
            rep_cnt      <= 2'd0;
            bus.cw_valid <= 1'b0;
            bus.cw_last  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        bus.dec_op <= bus.op_code;
                        rep_cnt    <= bus.op_rep;
                        state      <= DECODE;
                        busy       <= 1'b1;
                    end
                end
                DECODE: begin
                    bus.cw_data <= bus.dec_cw;
                    if (bus.dec_cw[MARK_BIT]) begin
                        state        <= ISSUE;
                        bus.cw_valid <= 1'b1;
                        bus.cw_last  <= (rep_cnt == 2'd0);
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                ISSUE: begin
                    if (beat) begin
                        if (rep_cnt != 2'd0) begin
                            rep_cnt     <= rep_cnt - 2'd1;
                            bus.cw_last <= (rep_cnt == 2'd1);
                        end else begin
                            issued_cnt   <= issued_cnt + CNT_W'(1);
                            bus.cw_valid <= 1'b0;
                            bus.cw_last  <= 1'b0;
                            if (accept) begin
                                bus.dec_op <= bus.op_code;
                                rep_cnt    <= bus.op_rep;
                                state      <= DECODE;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    state        <= IDLE;
                    bus.cw_valid <= 1'b0;
                    bus.cw_last  <= 1'b0;
                    busy         <= 1'b0;
                end
            endcase
        end
    end

    // Sticky decoder-marker error; a new error beats a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (err_set) begin
            err <= 1'b1;
        end else if (err_clr) begin
            err <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ctrl_sequencer.sv
// Self-checking bench for ctrl_sequencer: directed scenarios followed by a
// randomized run scored against a transaction-level beat queue.
module tb_ctrl_sequencer;
    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        busy;
    logic        err;
    logic        err_clr;
    logic [15:0] issued_cnt;

    int checks   = 0;
    int failures = 0;

    ctrl_sequencer_if bus_if ();

    ctrl_sequencer #(.CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus_if),
        .flush      (flush),
        .busy       (busy),
        .err        (err),
        .err_clr    (err_clr),
        .issued_cnt (issued_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in decoder: arbitrary scramble, marker low only for opcode 7'h7F
    function automatic logic [25:0] dec_model(input logic [6:0] op);
        logic [25:0] w;
        w     = (26'(op) * 26'd40503) ^ 26'h2A5C3E;
        w[23] = (op != 7'h7F);
        return w;
    endfunction

    always_comb bus_if.dec_cw = dec_model(bus_if.dec_op);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [25:0] data;
        logic        last;
    } beat_t;

    beat_t       q[$];
    beat_t       b;
    logic [15:0] exp_cnt;
    logic        pat [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    int          hs;
    logic        pend;
    logic [6:0]  p_code;
    logic [1:0]  p_rep;
    logic        saw_bad;
    logic        hold;
    logic [25:0] hold_data;
    logic        hold_last;

    initial begin
        rst_n           = 1'b0;
        flush           = 1'b0;
        err_clr         = 1'b0;
        bus_if.op_valid = 1'b0;
        bus_if.op_code  = '0;
        bus_if.op_rep   = '0;
        bus_if.cw_ready = 1'b0;
        exp_cnt         = '0;

        // Reset values
        @(negedge clk); @(negedge clk); #1;
        chk("rst_op_ready", 32'(bus_if.op_ready), 0);
        chk("rst_cw_valid", 32'(bus_if.cw_valid), 0);
        chk("rst_cw_last",  32'(bus_if.cw_last), 0);
        chk("rst_cw_data",  32'(bus_if.cw_data), 0);
        chk("rst_dec_op",   32'(bus_if.dec_op), 0);
        chk("rst_busy",     32'(busy), 0);
        chk("rst_err",      32'(err), 0);
        chk("rst_cnt",      32'(issued_cnt), 0);
        @(negedge clk); rst_n = 1'b1; #1;
        chk("first_ready", 32'(bus_if.op_ready), 1);

        // Single op, one beat
        @(negedge clk);
        bus_if.op_valid = 1'b1; bus_if.op_code = 7'h18; bus_if.op_rep = 2'd0;
        bus_if.cw_ready = 1'b1; #1;
        chk("t1_ready", 32'(bus_if.op_ready), 1);
        @(negedge clk); bus_if.op_valid = 1'b0; #1;
        chk("t1_dec_valid", 32'(bus_if.cw_valid), 0);
        chk("t1_dec_busy",  32'(busy), 1);
        chk("t1_dec_op",    32'(bus_if.dec_op), 32'h18);
        @(negedge clk); #1;
        chk("t1_valid", 32'(bus_if.cw_valid), 1);
        chk("t1_last",  32'(bus_if.cw_last), 1);
        chk("t1_data",  32'(bus_if.cw_data), 32'(dec_model(7'h18)));
        @(negedge clk); #1;
        exp_cnt = 16'd1;
        chk("t1_valid_drop", 32'(bus_if.cw_valid), 0);
        chk("t1_busy_drop",  32'(busy), 0);
        chk("t1_cnt",        32'(issued_cnt), 32'(exp_cnt));

        // Four beats with backpressure
        @(negedge clk);
        bus_if.op_valid = 1'b1; bus_if.op_code = 7'h25; bus_if.op_rep = 2'd3; #1;
        chk("t2_ready", 32'(bus_if.op_ready), 1);
        @(negedge clk); bus_if.op_valid = 1'b0; bus_if.cw_ready = 1'b0; #1;
        chk("t2_dec_busy", 32'(busy), 1);
        hs = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); bus_if.cw_ready = pat[i]; #1;
            chk("t2_valid", 32'(bus_if.cw_valid), 1);
            chk("t2_busy",  32'(busy), 1);
            chk("t2_data",  32'(bus_if.cw_data), 32'(dec_model(7'h25)));
            chk("t2_last",  32'(bus_if.cw_last), (hs == 3) ? 32'd1 : 32'd0);
            if (pat[i]) hs++;
        end
        @(negedge clk); #1;
        exp_cnt = exp_cnt + 16'd1;
        chk("t2_hs_count", 32'(hs), 4);
        chk("t2_valid_drop", 32'(bus_if.cw_valid), 0);
        chk("t2_cnt", 32'(issued_cnt), 32'(exp_cnt));

        // Back-to-back ops
        @(negedge clk);
        bus_if.op_valid = 1'b1; bus_if.op_code = 7'h31; bus_if.op_rep = 2'd0;
        bus_if.cw_ready = 1'b1; #1;
        chk("t3_ready_a", 32'(bus_if.op_ready), 1);
        @(negedge clk); bus_if.op_code = 7'h4C; #1;
        chk("t3_ready_dec", 32'(bus_if.op_ready), 0);
        @(negedge clk); #1;
        chk("t3_valid_a", 32'(bus_if.cw_valid), 1);
        chk("t3_data_a",  32'(bus_if.cw_data), 32'(dec_model(7'h31)));
        chk("t3_ready_b", 32'(bus_if.op_ready), 1);
        @(negedge clk); bus_if.op_valid = 1'b0; #1;
        chk("t3_gap_valid", 32'(bus_if.cw_valid), 0);
        chk("t3_gap_busy",  32'(busy), 1);
        chk("t3_gap_dec_op", 32'(bus_if.dec_op), 32'h4C);
        @(negedge clk); #1;
        chk("t3_valid_b", 32'(bus_if.cw_valid), 1);
        chk("t3_data_b",  32'(bus_if.cw_data), 32'(dec_model(7'h4C)));
        @(negedge clk); #1;
        exp_cnt = exp_cnt + 16'd2;
        chk("t3_cnt",  32'(issued_cnt), 32'(exp_cnt));
        chk("t3_busy", 32'(busy), 0);

        // Marker error, then clear racing a new error
        @(negedge clk);
        bus_if.op_valid = 1'b1; bus_if.op_code = 7'h7F; bus_if.op_rep = 2'd1; #1;
        @(negedge clk); bus_if.op_valid = 1'b0; #1;
        chk("t4_dec_valid", 32'(bus_if.cw_valid), 0);
        @(negedge clk); #1;
        chk("t4_valid", 32'(bus_if.cw_valid), 0);
        chk("t4_err",   32'(err), 1);
        chk("t4_busy",  32'(busy), 0);
        chk("t4_ready", 32'(bus_if.op_ready), 1);
        chk("t4_cnt",   32'(issued_cnt), 32'(exp_cnt));
        bus_if.op_valid = 1'b1;
        @(negedge clk); bus_if.op_valid = 1'b0; err_clr = 1'b1; #1;
        @(negedge clk); err_clr = 1'b0; #1;
        chk("t4_set_wins", 32'(err), 1);
        chk("t4_valid2",   32'(bus_if.cw_valid), 0);
        @(negedge clk); err_clr = 1'b1; #1;
        @(negedge clk); err_clr = 1'b0; #1;
        chk("t4_cleared", 32'(err), 0);

        // Flush during the second beat
        @(negedge clk);
        bus_if.op_valid = 1'b1; bus_if.op_code = 7'h0A; bus_if.op_rep = 2'd2;
        bus_if.cw_ready = 1'b1; #1;
        @(negedge clk); bus_if.op_valid = 1'b0; #1;
        @(negedge clk); #1;
        chk("t5_beat1", 32'(bus_if.cw_valid), 1);
        @(negedge clk);
        flush = 1'b1; bus_if.op_valid = 1'b1; bus_if.op_code = 7'h55; bus_if.op_rep = 2'd0; #1;
        chk("t5_beat2_valid", 32'(bus_if.cw_valid), 1);
        chk("t5_flush_ready", 32'(bus_if.op_ready), 0);
        @(negedge clk); flush = 1'b0; bus_if.op_valid = 1'b0; #1;
        chk("t5_valid_drop", 32'(bus_if.cw_valid), 0);
        chk("t5_busy",       32'(busy), 0);
        chk("t5_cnt",        32'(issued_cnt), 32'(exp_cnt));
        chk("t5_not_taken",  32'(bus_if.dec_op), 32'h0A);
        @(negedge clk); #1;
        chk("t5_still_idle", 32'(busy), 0);

        // Asynchronous reset mid-issue
        @(negedge clk);
        bus_if.op_valid = 1'b1; bus_if.op_code = 7'h66; bus_if.op_rep = 2'd3;
        bus_if.cw_ready = 1'b0; #1;
        @(negedge clk); bus_if.op_valid = 1'b0; #1;
        @(negedge clk); #1;
        chk("t6_issuing", 32'(bus_if.cw_valid), 1);
        #2 rst_n = 1'b0; #1;
        exp_cnt = '0;
        chk("t6_valid",    32'(bus_if.cw_valid), 0);
        chk("t6_last",     32'(bus_if.cw_last), 0);
        chk("t6_data",     32'(bus_if.cw_data), 0);
        chk("t6_dec_op",   32'(bus_if.dec_op), 0);
        chk("t6_busy",     32'(busy), 0);
        chk("t6_op_ready", 32'(bus_if.op_ready), 0);
        chk("t6_cnt",      32'(issued_cnt), 0);
        @(negedge clk); rst_n = 1'b1; bus_if.cw_ready = 1'b1; #1;
        chk("t6_ready_back", 32'(bus_if.op_ready), 1);

        // Counter wrap
        force dut.issued_cnt = 16'hFFFF;
        #1 release dut.issued_cnt;
        #1 chk("t7_preload", 32'(issued_cnt), 32'hFFFF);
        @(negedge clk);
        bus_if.op_valid = 1'b1; bus_if.op_code = 7'h12; bus_if.op_rep = 2'd0; #1;
        @(negedge clk); bus_if.op_valid = 1'b0; #1;
        @(negedge clk); #1;
        chk("t7_valid", 32'(bus_if.cw_valid), 1);
        @(negedge clk); #1;
        chk("t7_wrap", 32'(issued_cnt), 0);

        // Randomized traffic against the beat queue
        pend = 1'b0; saw_bad = 1'b0; hold = 1'b0;
        p_code = '0; p_rep = '0; hold_data = '0; hold_last = 1'b0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            if (!pend && cyc < 1470 && $urandom_range(0, 2) != 0) begin
                pend   = 1'b1;
                p_code = 7'($urandom_range(0, 127));
                if ($urandom_range(0, 7) == 0) p_code = 7'h7F;
                p_rep  = 2'($urandom_range(0, 3));
            end
            bus_if.op_valid = pend;
            bus_if.op_code  = p_code;
            bus_if.op_rep   = p_rep;
            bus_if.cw_ready = (cyc >= 1470) || ($urandom_range(0, 3) != 0);
            #1;
            chk("rnd_cnt", 32'(issued_cnt), 32'(exp_cnt));
            if (hold) begin
                chk("rnd_hold_valid", 32'(bus_if.cw_valid), 1);
                chk("rnd_hold_data",  32'(bus_if.cw_data), 32'(hold_data));
                chk("rnd_hold_last",  32'(bus_if.cw_last), 32'(hold_last));
            end
            if (bus_if.cw_valid && bus_if.cw_ready) begin
                if (q.size() == 0) begin
                    chk("rnd_spurious_beat", 32'(bus_if.cw_valid), 0);
                end else begin
                    b = q.pop_front();
                    chk("rnd_data", 32'(bus_if.cw_data), 32'(b.data));
                    chk("rnd_last", 32'(bus_if.cw_last), 32'(b.last));
                    if (b.last) exp_cnt = exp_cnt + 16'd1;
                end
            end
            if (bus_if.op_valid && bus_if.op_ready) begin
                if (dec_model(p_code)[23]) begin
                    for (int k = 0; k <= int'(p_rep); k++) begin
                        b.data = dec_model(p_code);
                        b.last = (k == int'(p_rep));
                        q.push_back(b);
                    end
                end else begin
                    saw_bad = 1'b1;
                end
                pend = 1'b0;
            end
            hold      = bus_if.cw_valid && !bus_if.cw_ready;
            hold_data = bus_if.cw_data;
            hold_last = bus_if.cw_last;
        end
        #1;
        chk("rnd_drained",   32'(q.size()), 0);
        chk("rnd_final_cnt", 32'(issued_cnt), 32'(exp_cnt));
        chk("rnd_idle",      32'(busy), 0);
        if (saw_bad) chk("rnd_err", 32'(err), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ctrl_sequencer.md
# ctrl_sequencer

Multi-cycle issue controller for the 7-bit-opcode / 26-bit-control-word decoder. It accepts opcodes over a valid/ready handshake and presents each one to the combinational decoder, holding it stable for one settle cycle. It captures the resulting control word and issues it downstream 1–4 times (repeat count supplied with the opcode), with a second valid/ready handshake. It sits between the instruction front end and the datapath control bus, and provides flush, error and issue-count status.

## Interface
- OPC_W, 7, opcode width (decoder input width)
- CW_W, 26, control-word width (decoder output width)
- CNT_W, 16, width of issued-op statistics counter
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- op_valid  in  1  upstream opcode valid
- op_ready  out  1  upstream opcode ready
- op_code  in  OPC_W  opcode
- op_rep  in  2  repeat count minus one (0→1 beat, 3→4 beats)
- dec_op  out  OPC_W  registered opcode driven to decoder
- dec_cw  in  CW_W  decoder control word (combinational from dec_op)
- cw_valid  out  1  downstream control word valid
- cw_ready  in  1  downstream ready
- cw_data  out  CW_W  registered control word
- cw_last  out  1  high on final beat of current op
- flush  in  1  synchronous abort
- busy  out  1  state ≠ IDLE
- err  out  1  sticky decoder-marker error
- err_clr  in  1  synchronous clear of err
- issued_cnt  out  CNT_W  completed ops, wraps modulo 2^CNT_W

## Operation
- FSM states: IDLE, DECODE, ISSUE.
- IDLE: op_ready=1. On op_valid&op_ready, latch op_code→dec_op and op_rep→rep_cnt, then go to DECODE.
- DECODE, one cycle: capture dec_cw into cw_data at the cycle end.
  - dec_cw[23] is the decoder valid marker and must be 1.
  - If dec_cw[23]=0, set err, drop the op (no beat issued, issued_cnt unchanged) and go to IDLE.
  - Otherwise go to ISSUE.
- ISSUE:
  - cw_valid=1; cw_data stable; cw_last=(rep_cnt==0).
  - On cw_valid&cw_ready with rep_cnt>0: decrement rep_cnt, stay in ISSUE, cw_data unchanged.
  - On the handshake with rep_cnt==0 (last beat): increment issued_cnt.
    - If op_valid is also high: op_ready=1 in that same cycle, the new opcode is latched, and the FSM goes to DECODE (back-to-back).
    - Otherwise go to IDLE.
- op_ready = (state==IDLE) | (state==ISSUE & cw_last & cw_ready), forced 0 while rst_n=0.
- flush (any state): next state IDLE, rep_cnt=0, cw_valid low next cycle.
  - flush has priority over every handshake in the same cycle.
  - An opcode presented in the flush cycle is not accepted (op_ready=0 that cycle).
  - A beat presented in the flush cycle does not count as transferred, even if cw_ready=1.
- err_clr clears err. If a set and a clear occur in the same cycle, set wins.
- dec_op holds its value in IDLE. The decoder output is ignored outside DECODE.

## Timing
- Reset values: state=IDLE, dec_op=0, cw_data=0, rep_cnt=0, cw_valid=0, cw_last=0, busy=0, err=0, issued_cnt=0, op_ready=0 while asserted.
  - The first op_ready=1 is in the first cycle after rst_n deasserts.
- Accept at edge k → DECODE in cycle k+1 → cw_valid=1 from cycle k+2. Latency is 2 cycles.
- With cw_ready tied high: op of N beats occupies N+1 cycles.
  - Sustained throughput is one op per (N+1) cycles via the back-to-back path.
- cw_valid, once high, stays high with cw_data/cw_last unchanged until the handshake or a flush.
- Reset asserted mid-op clears immediately (asynchronously); no partial beat completes.
- issued_cnt wraps from 2^CNT_W−1 to 0 with no flag.

## Test plan
- Reset then single op: op_code=7'h18, op_rep=0, dec_cw[23]=1, cw_ready=1.
  - Required: cw_valid exactly one cycle, 2 cycles after accept, cw_last=1, cw_data=dec_cw sampled in DECODE, issued_cnt=1.
- Repeat with backpressure: op_rep=3, cw_ready toggled 1,0,1,0,1,1.
  - Required: 4 handshakes, cw_data constant, cw_last only on the 4th, busy high throughout, issued_cnt+1.
- Back-to-back: two ops with op_rep=0 and op_valid held, cw_ready=1.
  - Required: second accepted in the cycle of the first's last beat, gap of exactly 1 DECODE cycle, issued_cnt+2.
- Marker error: dec_cw[23]=0 during DECODE.
  - Required: no cw_valid, err=1, FSM back in IDLE, issued_cnt unchanged.
  - Then assert err_clr with a simultaneous new error: err stays 1.
- Flush: flush during beat 2 of an op_rep=2 op, with cw_ready=1 in that cycle.
  - Required: beat not counted, cw_valid=0 next cycle, state IDLE, issued_cnt unchanged, op_valid during flush cycle not accepted.
- Async reset mid-ISSUE, then counter wrap.
  - Required: all outputs go to reset values without a clock edge.
  - Force issued_cnt to 16'hFFFF, complete one op: issued_cnt=0.
